commit_trace_unit: RTL and testbench
====================================

# commit_trace_unit

Hardware trace and health monitor downstream of the processor's retire and flush outputs. Every retired register write and every pipeline flush becomes a cycle-stamped record, buffered in a small FIFO and drained over a valid/ready port, so commit/flush traces survive into FPGA or emulation runs without file I/O. Also keeps commit/flush/drop counters and a sticky PC-hang flag that replaces simulation-only end detection.

## Interface
- DEPTH, 16: FIFO entries; power of 2, ≥4
- HANG_LIMIT, 500: consecutive cycles of unchanged PC that raise hang_o
- PC_W, 32: PC and flush-address width
- DATA_W, 32: commit data width
- PREG_W, 6: physical register tag width; tag field width of a record
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid_i  in  1  retired_instruction valid_commit
- commit_flushed_i  in  1  retired instruction was flushed
- commit_write_i  in  1  retired instruction writes a register
- commit_pdst_i  in  PREG_W  destination physical register
- commit_data_i  in  DATA_W  written data
- flush_valid_i  in  1  flush event
- flush_address_i  in  PC_W  redirect address
- flush_rob_ticket_i  in  3  ROB ticket of flushing instruction
- flush_rat_id_i  in  2  RAT checkpoint id
- flush_delayed_i  in  1  delayed-capture flag
- current_pc_i  in  PC_W  fetch PC
- trace_valid_o  out  1  head record valid
- trace_ready_i  in  1  consumer accepts head record
- trace_rec_o  out  trace_rec_t  head record: kind, cycle[31:0], payload[31:0], tag[PREG_W-1:0]
- commit_count_o  out  32  records of kind COMMIT accepted
- flush_count_o  out  32  records of kind FLUSH accepted
- drop_count_o  out  16  records lost to full FIFO, saturating
- hang_o  out  1  sticky PC-hang flag

## Operation
- Commit event: commit_valid_i & commit_write_i & ~commit_flushed_i → record {COMMIT, cycle, commit_data_i, commit_pdst_i}.
- Flush event: flush_valid_i → record {FLUSH, cycle, flush_address_i, {flush_rob_ticket_i, flush_rat_id_i, flush_delayed_i}} (6 bits, MSB first).
- cycle: free-running 32-bit counter, 0 in the first cycle after reset, wraps 0xFFFFFFFF→0; both records of one cycle carry the same stamp.
- FIFO: 2 writes, 1 read per cycle. Same-cycle order: COMMIT entry before FLUSH entry.
- Free space evaluated before this cycle's pop (a pop does not free a slot for same-cycle pushes). Two events with 1 free slot: COMMIT written, FLUSH dropped (+1 drop). Zero free slots: all events dropped (+1 or +2).
- Pop when trace_valid_o & trace_ready_i; trace_valid_o = (count ≠ 0).
- Counters increment only for records actually written; drop_count_o saturates at 0xFFFF; commit/flush counts wrap.
- Hang: last_pc register (reset 0); counter clears and last_pc loads when current_pc_i ≠ last_pc, otherwise increments, saturating at HANG_LIMIT; hang_o sets when counter reaches HANG_LIMIT, stays set until rst.

## Timing
- Reset: trace_valid_o 0, all counts 0, hang_o 0, FIFO empty, cycle 0, last_pc 0, hang counter 0.
- Event in cycle N → written at edge ending N → trace_valid_o earliest in N+1 (no fall-through).
- trace_rec_o stable while trace_valid_o & ~trace_ready_i.
- Counters reflect events of cycle N from N+1.
- rst mid-operation: buffered records discarded; events in the reset cycle ignored.
- Hang: PC constant from cycle 0 → hang_o high from cycle HANG_LIMIT+1 (counter resets to 0 on the first cycle, since last_pc = 0 ≠ PC, unless PC = 0).

## Structure
- trace_pkg: trace_kind_e {COMMIT=0, FLUSH=1}, trace_rec_t packed struct, TRACE_TAG_W.
- Sub-module trace_fifo_2w1r (DEPTH, element type trace_rec_t): two write ports with in-order commit, one read port, count output. Hang detector and counters stay in the top.

## Test plan
- Single commit (pdst 9, data 0xDEADBEEF) at cycle 5, ready=1 → record {COMMIT, 5, 0xDEADBEEF, 9} valid in cycle 6; commit_count_o=1.
- Commit with flushed=1, or write=0 → no record, counts unchanged.
- Same-cycle commit and flush (addr 0x100, rob 3, rat 2, delayed 1) → COMMIT popped first, then {FLUSH, same cycle, 0x100, 6'b011101}.
- ready=0, DEPTH−1 entries queued, then commit+flush together → FIFO full, COMMIT kept, drop_count_o=1; flush_count_o unchanged.
- current_pc_i held at 0x40 from reset → hang_o rises exactly at cycle 501; a PC change mid-count restarts counting; hang_o stays set after a later PC change.
- rst asserted with 5 buffered records → next cycle trace_valid_o=0, all counters 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared record format for the commit/flush trace path.
// The enum, the record struct and the record builder are kept here so the top and the FIFO agree on one layout.
package trace_pkg;
  localparam int TRACE_TAG_W = 6;

  typedef enum logic {COMMIT = 1'b0, FLUSH = 1'b1} trace_kind_e;

  typedef struct packed {
    trace_kind_e            kind;
    logic [31:0]            cycle;
    logic [31:0]            payload;
    logic [TRACE_TAG_W-1:0] tag;
  } trace_rec_t;

  function automatic trace_rec_t make_rec(trace_kind_e kind, logic [31:0] cycle,
                                          logic [31:0] payload, logic [TRACE_TAG_W-1:0] tag);
    trace_rec_t r;
    r.kind    = kind;
    r.cycle   = cycle;
    r.payload = payload;
    r.tag     = tag;
    return r;
  endfunction
endpackage

// File: rtl/trace_fifo_2w1r.sv
// Record FIFO with two in-order write ports and one read port.
// The caller only pushes what fits, so port b lands right behind port a when both push.
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a_i,
  input  trace_rec_t               data_a_i,
  input  logic                     push_b_i,
  input  trace_rec_t               data_b_i,
  input  logic                     pop_i,
  output trace_rec_t               head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  trace_rec_t       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_b;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       n_push;
  logic             pop_ok;

  always_comb begin
    n_push   = {1'b0, push_a_i} + {1'b0, push_b_i};
    pop_ok   = pop_i & (count_q != '0);
    wr_ptr_b = push_a_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + AW'(n_push);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_a_i) mem_q[wr_ptr_q] <= data_a_i;
      if (push_b_i) mem_q[wr_ptr_b] <= data_b_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/commit_trace_unit.sv
// Turns retired register writes and pipeline flushes into cycle-stamped trace records,
// keeps commit/flush/drop counters and a sticky PC-hang flag.
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int HANG_LIMIT = 500,
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int PREG_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid_i,
  input  logic              commit_flushed_i,
  input  logic              commit_write_i,
  input  logic [PREG_W-1:0] commit_pdst_i,
  input  logic [DATA_W-1:0] commit_data_i,
  input  logic              flush_valid_i,
  input  logic [PC_W-1:0]   flush_address_i,
  input  logic [2:0]        flush_rob_ticket_i,
  input  logic [1:0]        flush_rat_id_i,
  input  logic              flush_delayed_i,
  input  logic [PC_W-1:0]   current_pc_i,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output trace_rec_t        trace_rec_o,
  output logic [31:0]       commit_count_o,
  output logic [31:0]       flush_count_o,
  output logic [15:0]       drop_count_o,
  output logic              hang_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int HW    = $clog2(HANG_LIMIT + 1);

  logic [31:0]      cycle_q, commit_count_q, flush_count_q;
  logic [15:0]      drop_count_q, drop_count_d;
  logic [16:0]      drop_sum;
  logic [PC_W-1:0]  last_pc_q;
  logic [HW-1:0]    hang_cnt_q, hang_cnt_d;
  logic             hang_q;
  logic [CNT_W-1:0] fifo_count, free;
  logic             commit_ev, flush_ev, wr_commit, wr_flush, pop;
  logic [1:0]       n_drop;
  trace_rec_t       commit_rec, flush_rec;

  // Trace port: the head record transfers on a cycle where trace_valid_o and trace_ready_i
  // are both high; while ready is low the head record is held unchanged.
  assign trace_valid_o = (fifo_count != '0);
  assign pop           = trace_valid_o & trace_ready_i;

  always_comb begin
    commit_ev  = commit_valid_i & commit_write_i & ~commit_flushed_i;
    flush_ev   = flush_valid_i;
    commit_rec = make_rec(COMMIT, cycle_q, 32'(commit_data_i), TRACE_TAG_W'(commit_pdst_i));
    flush_rec  = make_rec(FLUSH, cycle_q, 32'(flush_address_i),
                          {flush_rob_ticket_i, flush_rat_id_i, flush_delayed_i});
    // Space is judged before this cycle's pop, and COMMIT claims a slot ahead of FLUSH.
    free      = CNT_W'(DEPTH) - fifo_count;
    wr_commit = commit_ev & (free != '0);
    wr_flush  = flush_ev & (free > CNT_W'(wr_commit));
    n_drop    = {1'b0, commit_ev & ~wr_commit} + {1'b0, flush_ev & ~wr_flush};
    drop_sum  = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (current_pc_i != last_pc_q)       hang_cnt_d = '0;
    else if (hang_cnt_q != HW'(HANG_LIMIT)) hang_cnt_d = hang_cnt_q + HW'(1);
    else                                 hang_cnt_d = hang_cnt_q;
  end

  trace_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a_i (wr_commit),
    .data_a_i (commit_rec),
    .push_b_i (wr_flush),
    .data_b_i (flush_rec),
    .pop_i    (pop),
    .head_o   (trace_rec_o),
    .count_o  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q        <= '0;
      commit_count_q <= '0;
      flush_count_q  <= '0;
      drop_count_q   <= '0;
      last_pc_q      <= '0;
      hang_cnt_q     <= '0;
      hang_q         <= 1'b0;
    end else begin
      cycle_q        <= cycle_q + 32'd1;
      commit_count_q <= commit_count_q + 32'(wr_commit);
      flush_count_q  <= flush_count_q + 32'(wr_flush);
      drop_count_q   <= drop_count_d;
      last_pc_q      <= current_pc_i;
      hang_cnt_q     <= hang_cnt_d;
      hang_q         <= hang_q | (hang_cnt_d == HW'(HANG_LIMIT));
    end
  end

  assign commit_count_o = commit_count_q;
  assign flush_count_o  = flush_count_q;
  assign drop_count_o   = drop_count_q;
  assign hang_o         = hang_q;
endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench for commit_trace_unit: a vector table for single-cycle events plus
// hand-written sequences for FIFO overflow, mid-run reset and PC-hang detection.
module tb_commit_trace_unit;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid_i, commit_flushed_i, commit_write_i;
  logic [5:0]  commit_pdst_i;
  logic [31:0] commit_data_i;
  logic        flush_valid_i;
  logic [31:0] flush_address_i;
  logic [2:0]  flush_rob_ticket_i;
  logic [1:0]  flush_rat_id_i;
  logic        flush_delayed_i;
  logic [31:0] current_pc_i;
  logic        trace_valid_o, trace_ready_i;
  trace_rec_t  trace_rec_o;
  logic [31:0] commit_count_o, flush_count_o;
  logic [15:0] drop_count_o;
  logic        hang_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  trace_rec_t  exp_q[$];

  always #5 clk = ~clk;

  commit_trace_unit #(.DEPTH(DEPTH), .HANG_LIMIT(500), .PC_W(32), .DATA_W(32), .PREG_W(6)) dut (
    .clk(clk), .rst(rst),
    .commit_valid_i(commit_valid_i), .commit_flushed_i(commit_flushed_i),
    .commit_write_i(commit_write_i), .commit_pdst_i(commit_pdst_i), .commit_data_i(commit_data_i),
    .flush_valid_i(flush_valid_i), .flush_address_i(flush_address_i),
    .flush_rob_ticket_i(flush_rob_ticket_i), .flush_rat_id_i(flush_rat_id_i),
    .flush_delayed_i(flush_delayed_i), .current_pc_i(current_pc_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_rec_o(trace_rec_o),
    .commit_count_o(commit_count_o), .flush_count_o(flush_count_o),
    .drop_count_o(drop_count_o), .hang_o(hang_o)
  );

  typedef struct {
    logic        cv, cf, cw;
    logic [5:0]  pdst;
    logic [31:0] data;
    logic        fv;
    logic [31:0] addr;
    logic [2:0]  rob;
    logic [1:0]  rat;
    logic        dly;
    int          n;
    logic        k0;
    logic [31:0] p0;
    logic [5:0]  t0;
    logic        k1;
    logic [31:0] p1;
    logic [5:0]  t1;
    logic [31:0] cc, fc;
  } vec_t;

  vec_t vecs[7];

  function automatic trace_rec_t rec(input logic k, input logic [31:0] c, input logic [31:0] p,
                                     input logic [5:0] t);
    trace_rec_t r;
    r.kind = trace_kind_e'(k);
    r.cycle = c;
    r.payload = p;
    r.tag = t;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    commit_valid_i = 0; commit_flushed_i = 0; commit_write_i = 0;
    commit_pdst_i = '0; commit_data_i = '0;
    flush_valid_i = 0; flush_address_i = '0; flush_rob_ticket_i = '0;
    flush_rat_id_i = '0; flush_delayed_i = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic drive_commit(input logic [5:0] pdst, input logic [31:0] data);
    commit_valid_i = 1; commit_write_i = 1; commit_flushed_i = 0;
    commit_pdst_i = pdst; commit_data_i = data;
  endtask

  task automatic drive_flush(input logic [31:0] addr, input logic [2:0] rob, input logic [1:0] rat,
                             input logic dly);
    flush_valid_i = 1; flush_address_i = addr; flush_rob_ticket_i = rob;
    flush_rat_id_i = rat; flush_delayed_i = dly;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    trace_ready_i = 1'b1;
    current_pc_i = 32'h40;
    clear_inputs();

    vecs[0] = '{1,0,1, 6'd9,  32'hDEADBEEF, 0, 32'h0,        3'd0, 2'd0, 0, 1,
                0, 32'hDEADBEEF, 6'd9,       0, 32'h0,   6'd0, 32'd1, 32'd0};
    vecs[1] = '{1,1,1, 6'd5,  32'h11111111, 0, 32'h0,        3'd0, 2'd0, 0, 0,
                0, 32'h0, 6'd0,              0, 32'h0,   6'd0, 32'd1, 32'd0};
    vecs[2] = '{1,0,0, 6'd5,  32'h22222222, 0, 32'h0,        3'd0, 2'd0, 0, 0,
                0, 32'h0, 6'd0,              0, 32'h0,   6'd0, 32'd1, 32'd0};
    vecs[3] = '{1,0,1, 6'd42, 32'h12345678, 1, 32'h100,      3'd3, 2'd2, 1, 2,
                0, 32'h12345678, 6'd42,      1, 32'h100, 6'b011101, 32'd2, 32'd1};
    vecs[4] = '{0,0,0, 6'd0,  32'h0,        1, 32'hFFFFFFFC, 3'd7, 2'd0, 0, 1,
                1, 32'hFFFFFFFC, 6'b111000,  0, 32'h0,   6'd0, 32'd2, 32'd2};
    vecs[5] = '{1,1,1, 6'd7,  32'h33333333, 1, 32'h2000,     3'd1, 2'd1, 0, 1,
                1, 32'h2000, 6'b001010,      0, 32'h0,   6'd0, 32'd2, 32'd3};
    vecs[6] = '{1,0,1, 6'd63, 32'h0,        0, 32'h0,        3'd0, 2'd0, 0, 1,
                0, 32'h0, 6'd63,             0, 32'h0,   6'd0, 32'd3, 32'd3};

    // Reset state
    do_reset();
    check("reset_valid", 128'(trace_valid_o), 128'(0));
    check("reset_commit_count", 128'(commit_count_o), 128'(0));
    check("reset_flush_count", 128'(flush_count_o), 128'(0));
    check("reset_drop_count", 128'(drop_count_o), 128'(0));
    check("reset_hang", 128'(hang_o), 128'(0));

    // Table vectors; the first lands in cycle 5
    repeat (5) step();
    for (int i = 0; i < 7; i++) begin
      c = cyc;
      commit_valid_i = vecs[i].cv; commit_flushed_i = vecs[i].cf; commit_write_i = vecs[i].cw;
      commit_pdst_i = vecs[i].pdst; commit_data_i = vecs[i].data;
      flush_valid_i = vecs[i].fv; flush_address_i = vecs[i].addr;
      flush_rob_ticket_i = vecs[i].rob; flush_rat_id_i = vecs[i].rat; flush_delayed_i = vecs[i].dly;
      check($sformatf("v%0d_no_fallthrough", i), 128'(trace_valid_o), 128'(0));
      step();
      clear_inputs();
      check($sformatf("v%0d_valid", i), 128'(trace_valid_o), 128'(vecs[i].n != 0));
      check($sformatf("v%0d_commit_count", i), 128'(commit_count_o), 128'(vecs[i].cc));
      check($sformatf("v%0d_flush_count", i), 128'(flush_count_o), 128'(vecs[i].fc));
      if (vecs[i].n >= 1)
        check($sformatf("v%0d_rec0", i), 128'(trace_rec_o),
              128'(rec(vecs[i].k0, c, vecs[i].p0, vecs[i].t0)));
      if (vecs[i].n == 2) begin
        step();
        check($sformatf("v%0d_valid1", i), 128'(trace_valid_o), 128'(1));
        check($sformatf("v%0d_rec1", i), 128'(trace_rec_o),
              128'(rec(vecs[i].k1, c, vecs[i].p1, vecs[i].t1)));
      end
      if (vecs[i].n >= 1) step();
      check($sformatf("v%0d_empty_after", i), 128'(trace_valid_o), 128'(0));
    end
    check("table_drop_count", 128'(drop_count_o), 128'(0));

    // Overflow: fill DEPTH-1, then commit+flush with one slot free
    do_reset();
    trace_ready_i = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive_commit(6'(i), 32'h1000 + 32'(i));
      exp_q.push_back(rec(0, cyc, 32'h1000 + 32'(i), 6'(i)));
      step();
    end
    clear_inputs();
    drive_commit(6'd15, 32'hAAAA);
    drive_flush(32'h500, 3'd1, 2'd1, 1);
    exp_q.push_back(rec(0, cyc, 32'hAAAA, 6'd15));
    step();
    clear_inputs();
    check("ovf_drop1", 128'(drop_count_o), 128'(1));
    check("ovf_commit16", 128'(commit_count_o), 128'(16));
    check("ovf_flush_unchanged", 128'(flush_count_o), 128'(0));
    check("ovf_head_stable", 128'(trace_rec_o), 128'(exp_q[0]));
    // Full FIFO: both events lost
    drive_commit(6'd1, 32'hBBBB);
    drive_flush(32'h600, 3'd2, 2'd0, 0);
    step();
    clear_inputs();
    check("full_drop3", 128'(drop_count_o), 128'(3));
    check("full_commit16", 128'(commit_count_o), 128'(16));
    // Pop in the same cycle does not make room for a push
    trace_ready_i = 1;
    drive_commit(6'd2, 32'hCCCC);
    check("full_head", 128'(trace_rec_o), 128'(exp_q.pop_front()));
    step();
    clear_inputs();
    check("pop_no_room_drop4", 128'(drop_count_o), 128'(4));
    check("pop_no_room_commit16", 128'(commit_count_o), 128'(16));
    for (int k = 0; k < 40 && trace_valid_o; k++) begin
      if (exp_q.size() == 0) begin
        check("drain_extra_record", 128'(trace_rec_o), 128'(0));
        break;
      end
      check($sformatf("drain_%0d", k), 128'(trace_rec_o), 128'(exp_q.pop_front()));
      step();
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    check("drain_valid_low", 128'(trace_valid_o), 128'(0));

    // Reset with 5 buffered records; the reset-cycle event is ignored
    trace_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      drive_commit(6'(i), 32'(i));
      step();
    end
    check("pre_rst_commit_count", 128'(commit_count_o), 128'(21));
    rst = 1;
    step();
    rst = 0;
    clear_inputs();
    check("mid_rst_valid", 128'(trace_valid_o), 128'(0));
    check("mid_rst_commit", 128'(commit_count_o), 128'(0));
    check("mid_rst_flush", 128'(flush_count_o), 128'(0));
    check("mid_rst_drop", 128'(drop_count_o), 128'(0));
    step();
    check("mid_rst_valid_next", 128'(trace_valid_o), 128'(0));
    trace_ready_i = 1;

    // Hang: PC 0x40 from reset
    current_pc_i = 32'h40;
    do_reset();
    while (cyc < 500) step();
    check("hang_low_500", 128'(hang_o), 128'(0));
    step();
    check("hang_high_501", 128'(hang_o), 128'(1));

    // PC change at cycle 300 restarts the count; hang then rises at 801
    do_reset();
    while (cyc < 300) step();
    current_pc_i = 32'h44;
    while (cyc < 800) step();
    check("hang_restart_low_800", 128'(hang_o), 128'(0));
    step();
    check("hang_restart_high_801", 128'(hang_o), 128'(1));
    current_pc_i = 32'h80;
    repeat (3) step();
    check("hang_sticky", 128'(hang_o), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
